triumph_wb_stage: RTL

TRIUMPH_WB_STAGE -- requirements
Module: triumph_wb_stage

---
 rtl/triumph_wb_stage_pkg.sv | 25 ++
 rtl/triumph_riscv_defines.v | 7 +
 rtl/triumph_wb_fifo.sv | 95 +++++++++
 rtl/triumph_wb_stage.sv | 107 ++++++++++
 4 files changed

// File: rtl/triumph_wb_stage_pkg.sv
// Types and widths shared by the writeback stage and its pending-write FIFO.
// Widths come from the core-wide defines; the guarded block mirrors them when that header is not read first.
`ifndef TRIUMPH_RISCV_DEFINES_V
`define TRIUMPH_RISCV_DEFINES_V
`define TRIUMPH_REG_ADDR_W 5
`define TRIUMPH_DATA_W 32
`endif

package triumph_wb_stage_pkg;

    localparam int unsigned REG_AW = `TRIUMPH_REG_ADDR_W;
    localparam int unsigned DATA_W = `TRIUMPH_DATA_W;

    typedef enum logic [1:0] {
        WB_EMPTY   = 2'd0,
        WB_PARTIAL = 2'd1,
        WB_FULL    = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/triumph_riscv_defines.v
// Shared core-wide widths for the Triumph RISC-V pipeline.
// Define TRIUMPH_WB_FWD_EN ahead of this header to enable the writeback bypass lookup; it is off by default.
`ifndef TRIUMPH_RISCV_DEFINES_V
`define TRIUMPH_RISCV_DEFINES_V
`define TRIUMPH_REG_ADDR_W 5
`define TRIUMPH_DATA_W 32
`endif

// File: rtl/triumph_wb_fifo.sv
// Pending-writeback FIFO: entry storage, head/tail pointers, occupancy and the EMPTY/PARTIAL/FULL state.
// With TRIUMPH_WB_FWD_EN defined, storage, head pointer and occupancy are exported for the bypass lookup.
module triumph_wb_fifo
    import triumph_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  wb_entry_t                  entry_i,
    input  logic                       pop_i,
    output wb_entry_t                  head_o,
    output wb_state_e                  state_o,
`ifdef TRIUMPH_WB_FWD_EN
    output wb_entry_t                  mem_o [DEPTH],
    output logic [$clog2(DEPTH)-1:0]   head_ptr_o,
    output logic [$clog2(DEPTH):0]     occ_o,
`endif
    output logic                       unused_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    wb_state_e        state_q, state_d;
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Push is refused while FULL even if a pop happens in the same cycle.
    assign do_push = push_i && (state_q != WB_FULL);
    assign do_pop  = pop_i && (state_q != WB_EMPTY);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        state_d = state_q;
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[tail_q] = entry_i;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (occ_d == '0) begin
            state_d = WB_EMPTY;
        end else if (occ_d == OCC_W'(DEPTH)) begin
            state_d = WB_FULL;
        end else begin
            state_d = WB_PARTIAL;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            state_q <= WB_EMPTY;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            state_q <= state_d;
        end
    end

    // Storage is deliberately not reset; the state gates every read of it.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign head_o   = (state_q != WB_EMPTY) ? mem_q[head_q] : '0;
    assign state_o  = state_q;
    assign unused_o = 1'b0;

`ifdef TRIUMPH_WB_FWD_EN
    assign mem_o      = mem_q;
    assign head_ptr_o = head_q;
    assign occ_o      = occ_q;
`endif

endmodule

// File: rtl/triumph_wb_stage.sv
// Writeback stage: buffers EX results ahead of the regfile write port, drops x0 writes, counts retired writes.
// Defining TRIUMPH_WB_FWD_EN adds a combinational bypass lookup over pending entries.
module triumph_wb_stage
    import triumph_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic [DATA_W-1:0] ex_rd_data_i,
    output logic              ex_ready_o,
    output logic              rf_we_o,
    output logic [REG_AW-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic              rf_ready_i,
`ifdef TRIUMPH_WB_FWD_EN
    input  logic [REG_AW-1:0] fwd_rs_addr_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
`endif
    output logic [31:0]       retire_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    wb_entry_t   head;
    wb_entry_t   push_entry;
    wb_state_e   wb_state;
    logic        push;
    logic        pop;
    logic        fifo_unused;
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Ready and write-request decode only the registered state, never rf_ready_i.
    assign ex_ready_o = (wb_state != WB_FULL);
    assign rf_we_o    = (wb_state != WB_EMPTY);
    assign rf_waddr_o = head.addr;
    assign rf_wdata_o = head.data;

    // x0 results are accepted but never buffered.
    assign push       = ex_valid_i && ex_ready_o && (ex_rd_addr_i != '0);
    assign pop        = rf_we_o && rf_ready_i;
    assign push_entry = '{addr: ex_rd_addr_i, data: ex_rd_data_i};

`ifdef TRIUMPH_WB_FWD_EN
    wb_entry_t        fwd_mem [DEPTH];
    logic [PTR_W-1:0] fwd_head_ptr;
    logic [OCC_W-1:0] fwd_occ;
    logic [PTR_W-1:0] fwd_idx;
`endif

    triumph_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .entry_i    (push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .state_o    (wb_state),
`ifdef TRIUMPH_WB_FWD_EN
        .mem_o      (fwd_mem),
        .head_ptr_o (fwd_head_ptr),
        .occ_o      (fwd_occ),
`endif
        .unused_o   (fifo_unused)
    );

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (pop && !fifo_unused) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt_o = retire_cnt_q;

`ifdef TRIUMPH_WB_FWD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = fwd_head_ptr + PTR_W'(k);
            if ((OCC_W'(k) < fwd_occ) && (fwd_rs_addr_i != '0) &&
                (fwd_mem[fwd_idx].addr == fwd_rs_addr_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = fwd_mem[fwd_idx].data;
            end
        end
    end
`endif

endmodule
